// File: rtl/axis_frame_transmitter.sv
// ---------------------------------------------------------------------------
// axis_frame_transmitter
//
// Byte-wide AXI-Stream frame source. Local logic pushes bytes into an
// internal FIFO, then pulses start with a frame length. The block emits
// exactly frame_len beats and marks the last one with Tlast. A 5-bit
// frame counter counts completed frames, matching the receiving end's
// frame_cnt so both ends can be compared directly.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   wr_en        push wr_data into the FIFO
//   wr_data      byte to push
//   fifo_full    FIFO holds DEPTH bytes
//   fifo_count   registered FIFO occupancy
//   wr_overflow  one-cycle pulse: wr_en while full, byte dropped
//   start        begin a frame (sampled only in IDLE)
//   frame_len    beats in the frame, sampled with start
//   busy         high while a frame is being sent (state == SEND)
//   T_valid_out  out_data holds a beat
//   T_ready      downstream accepts the beat
//   Tlast        qualifies the final beat of a frame
//   out_data     stream byte
//   frame_cnt    completed frames, wraps 31 -> 0
//
// Handshake: a beat transfers on a rising edge where T_valid_out and
// T_ready are both high. Once T_valid_out is raised, out_data, Tlast and
// T_valid_out stay stable until that transfer happens; valid never drops
// without a transfer, and never waits on T_ready before rising.
//
// The FSM has only two states, so busy is the direct view of the state
// register and serves as its debug output.
// ---------------------------------------------------------------------------
module axis_frame_transmitter #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       wr_overflow,
  input  logic                       start,
  input  logic [LEN_W-1:0]           frame_len,
  output logic                       busy,
  output logic                       T_valid_out,
  input  logic                       T_ready,
  output logic                       Tlast,
  output logic [7:0]                 out_data,
  output logic [4:0]                 frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO storage. Pointers are AW bits wide and wrap naturally because
  // DEPTH is a power of two; the separate count disambiguates full/empty.
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic fifo_empty;
  logic push;
  logic pop;

  // ---------------------------------------------------------------------
  // Control / output stage registers and their next values
  // ---------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             t_valid_q,   t_valid_d;
  logic             tlast_q,     tlast_d;
  logic [7:0]       out_data_q,  out_data_d;
  logic [4:0]       frame_cnt_q, frame_cnt_d;

  logic transfer;
  logic frame_done;
  logic load;

  // Full is taken from the registered count, so a pop in the same cycle
  // does not make room for a write in that cycle.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign push       = wr_en && !fifo_full;

  assign transfer   = t_valid_q && T_ready;
  assign frame_done = transfer && tlast_q;

  // The output register can take a new byte when it is empty or its
  // current beat is leaving this cycle. Loading is what pops the FIFO.
  assign load = (state_q == SEND) && (remaining_q != '0) && !fifo_empty &&
                (!t_valid_q || T_ready);
  assign pop  = load;

  // ---------------------------------------------------------------------
  // FIFO write port (storage needs no reset; occupancy lives in count_q)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO pointers, occupancy and overflow flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr_en && fifo_full;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and output-stage logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    t_valid_d   = t_valid_q;
    tlast_d     = tlast_q;
    out_data_d  = out_data_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        // A zero-length request has nothing to send and is dropped.
        if (start && (frame_len != '0)) begin
          state_d     = SEND;
          remaining_d = frame_len;
        end
      end

      SEND: begin
        if (load) begin
          out_data_d  = mem[rd_ptr_q];
          t_valid_d   = 1'b1;
          tlast_d     = (remaining_q == LEN_W'(1));
          remaining_d = remaining_q - LEN_W'(1);
        end else if (transfer) begin
          // Beat left and nothing replaced it: a bubble on underrun, or
          // the idle gap after the last beat.
          t_valid_d = 1'b0;
          tlast_d   = 1'b0;
        end

        // The last beat was loaded with remaining==1, so remaining is 0
        // here and no load can coincide with frame completion.
        if (frame_done) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 5'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State and output-stage registers. Reset abandons any frame in flight
  // without counting it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      t_valid_q   <= 1'b0;
      tlast_q     <= 1'b0;
      out_data_q  <= 8'h00;
      frame_cnt_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      t_valid_q   <= t_valid_d;
      tlast_q     <= tlast_d;
      out_data_q  <= out_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign fifo_count  = count_q;
  assign wr_overflow = overflow_q;
  assign busy        = (state_q == SEND);
  assign T_valid_out = t_valid_q;
  assign Tlast       = tlast_q;
  assign out_data    = out_data_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
